// File: rtl/booth_mult_arbiter_8_bit_if.sv
// Request/response bus of the shared Booth multiplier.
// Ports (signals):
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : product handshake
//   rsp_prod/rsp_id     : signed product and owning requester index
//   busy                : multiplier not idle
// Modports: master = requester/consumer side, slave = multiplier side.
interface booth_mult_arbiter_8_bit_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );
endinterface

// File: rtl/booth_mult_arbiter_8_bit.sv
// Shared sequential radix-2 Booth multiplier with a round-robin front end.
// One requester is granted in IDLE, the product is built one Booth step per
// cycle in CALC, and returned with the requester index in RESP.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of booth_mult_arbiter_8_bit_if (requests, response, busy)
module booth_mult_arbiter_8_bit #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    booth_mult_arbiter_8_bit_if.slave    bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned P_W   = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [P_W-1:0]     p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;

    logic [N_REQ-1:0]   req_ready_c;
    logic [ID_W-1:0]    gnt_idx_c;
    logic [ID_W-1:0]    cand_c;
    logic               grant_c;
    logic [P_W-1:0]     a_ext_c;
    logic [P_W-1:0]     sum_c;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        req_ready_c = '0;
        gnt_idx_c   = '0;
        cand_c      = '0;
        grant_c     = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = ID_W'((32'(last_q) + k) % N_REQ);
            if (!grant_c && (state_q == IDLE) && !rst && bus.req_valid[cand_c]) begin
                grant_c             = 1'b1;
                gnt_idx_c           = cand_c;
                req_ready_c[cand_c] = 1'b1;
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        a_ext_c = {a_q[WIDTH-1], a_q};
        sum_c   = p_q;

        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    a_d     = bus.req_a[32'(gnt_idx_c)*WIDTH +: WIDTH];
                    q_d     = bus.req_b[32'(gnt_idx_c)*WIDTH +: WIDTH];
                    qm1_d   = 1'b0;
                    p_d     = '0;
                    cnt_d   = '0;
                    id_d    = gnt_idx_c;
                    last_d  = gnt_idx_c;
                    state_d = CALC;
                end
            end
            CALC: begin
                unique case ({q_q[0], qm1_q})
                    2'b10:   sum_c = p_q - a_ext_c;
                    2'b01:   sum_c = p_q + a_ext_c;
                    default: sum_c = p_q;
                endcase
                // Arithmetic shift of {P, Q, q_m1}; P keeps its sign
                p_d   = {sum_c[P_W-1], sum_c[P_W-1:1]};
                q_d   = {sum_c[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            p_q     <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Response fields are forced to zero outside RESP so reset and idle read 0
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_prod  = (state_q == RESP) ? {p_q[WIDTH-1:0], q_q} : '0;
    assign bus.rsp_id    = (state_q == RESP) ? id_q : '0;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter_8_bit.sv
module tb_booth_mult_arbiter_8_bit;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    booth_mult_arbiter_8_bit_if #(.N_REQ(4), .WIDTH(8), .ID_W(2)) bif ();

    booth_mult_arbiter_8_bit #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
        bif.req_a[idx*8 +: 8] = a;
        bif.req_b[idx*8 +: 8] = b;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Bounded wait for rsp_valid; returns 1 when seen
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bif.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.req_valid = 4'b1111;
        bif.req_a = '0;
        bif.req_b = '0;
        bif.rsp_ready = 1'b1;
        #2;
        n_checks++;
        if (bif.req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b want 0000", bif.req_ready);
        else n_pass++;
        n_checks++;
        if ({bif.rsp_valid, bif.busy} !== 2'b00) $display("FAIL reset_valid_busy got %b want 00", {bif.rsp_valid, bif.busy});
        else n_pass++;
        n_checks++;
        if ({bif.rsp_prod, bif.rsp_id} !== 18'h0) $display("FAIL reset_prod_id got %h want 0", {bif.rsp_prod, bif.rsp_id});
        else n_pass++;
        bif.req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_op(0, 8'sd7, -8'sd3);
        bif.req_valid = 4'b0001;
        bif.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bif.req_ready !== 4'b0001) $display("FAIL single_grant got %b want 0001", bif.req_ready);
        else n_pass++;
        tick();
        bif.req_valid = 4'b0000;
        #1;
        n_checks++;
        if ({bif.req_ready, bif.busy} !== 5'b00001) $display("FAIL single_after_accept got %b want 00001", {bif.req_ready, bif.busy});
        else n_pass++;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (bif.rsp_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", bif.rsp_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({bif.rsp_valid, bif.busy} !== 2'b11) $display("FAIL single_latency got %b want 11", {bif.rsp_valid, bif.busy});
        else n_pass++;
        n_checks++;
        if ({bif.rsp_prod, bif.rsp_id} !== {16'hFFEB, 2'd0}) $display("FAIL single_prod got %h/%0d want ffeb/0", bif.rsp_prod, bif.rsp_id);
        else n_pass++;
        tick();
        n_checks++;
        if ({bif.rsp_valid, bif.busy} !== 2'b00) $display("FAIL single_release got %b want 00", {bif.rsp_valid, bif.busy});
        else n_pass++;
    endtask

    task automatic test_corners();
        logic [7:0]  ca [5] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
        logic [7:0]  cb [5] = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hFF};
        logic [15:0] cp [5] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001};
        logic [3:0]  vmask;
        bit          ok;
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(i % 4, ca[i], cb[i]);
            vmask = '0;
            vmask[i % 4] = 1'b1;
            bif.req_valid = vmask;
            tick();
            bif.req_valid = 4'b0000;
            wait_rsp(ok);
            n_checks++;
            if (!ok) $display("FAIL corner%0d timeout waiting rsp_valid", i);
            else if ({bif.rsp_prod, bif.rsp_id} !== {cp[i], 2'(i % 4)})
                $display("FAIL corner%0d got %h/%0d want %h/%0d", i, bif.rsp_prod, bif.rsp_id, cp[i], i % 4);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] rp [4] = '{16'h000F, 16'hFFE8, 16'hFF9C, 16'h003F};
        int          gexp [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0]  oh;
        int          last_cyc;
        int          gcyc;
        bit          ok;
        apply_reset();
        set_op(0, 8'sd3, 8'sd5);
        set_op(1, -8'sd4, 8'sd6);
        set_op(2, 8'sd10, -8'sd10);
        set_op(3, -8'sd7, -8'sd9);
        bif.rsp_ready = 1'b1;
        bif.req_valid = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 6; g++) begin
            #1;
            for (int w = 0; w < 20 && bif.req_ready === 4'b0000; w++) tick();
            gcyc = cyc;
            oh = '0;
            oh[gexp[g]] = 1'b1;
            n_checks++;
            if (bif.req_ready !== oh) $display("FAIL rr_grant%0d got %b want %b", g, bif.req_ready, oh);
            else n_pass++;
            if (g > 0) begin
                n_checks++;
                if (gcyc - last_cyc !== 10) $display("FAIL rr_interval%0d got %0d want 10", g, gcyc - last_cyc);
                else n_pass++;
            end
            last_cyc = gcyc;
            tick();
            wait_rsp(ok);
            n_checks++;
            if (!ok) $display("FAIL rr_rsp%0d timeout waiting rsp_valid", g);
            else if ({bif.rsp_prod, bif.rsp_id} !== {rp[gexp[g]], 2'(gexp[g])})
                $display("FAIL rr_rsp%0d got %h/%0d want %h/%0d", g, bif.rsp_prod, bif.rsp_id, rp[gexp[g]], gexp[g]);
            else n_pass++;
            tick();
        end
    endtask

    // Continues from round-robin: last grant was requester 1, all still valid
    task automatic test_backpressure();
        bit ok;
        bif.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (bif.req_ready !== 4'b0100) $display("FAIL bp_grant got %b want 0100", bif.req_ready);
        else n_pass++;
        tick();
        wait_rsp(ok);
        n_checks++;
        if (!ok) $display("FAIL bp_rsp timeout waiting rsp_valid");
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bif.rsp_valid, bif.rsp_prod, bif.rsp_id, bif.req_ready} !== {1'b1, 16'hFF9C, 2'd2, 4'b0000})
                $display("FAIL bp_hold%0d got %b/%h/%0d/%b want 1/ff9c/2/0000",
                         i, bif.rsp_valid, bif.rsp_prod, bif.rsp_id, bif.req_ready);
            else n_pass++;
        end
        bif.rsp_ready = 1'b1;
        tick();
        n_checks++;
        if ({bif.rsp_valid, bif.busy, bif.req_ready} !== {2'b00, 4'b1000})
            $display("FAIL bp_release got %b/%b/%b want 0/0/1000", bif.rsp_valid, bif.busy, bif.req_ready);
        else n_pass++;
        bif.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        bit ok;
        set_op(1, 8'sd5, 8'sd5);
        bif.req_valid = 4'b0010;
        bif.rsp_ready = 1'b1;
        tick();
        bif.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bif.rsp_valid, bif.busy, bif.req_ready} !== 6'b0) $display("FAIL arst_ctrl got %b want 000000", {bif.rsp_valid, bif.busy, bif.req_ready});
        else n_pass++;
        n_checks++;
        if ({bif.rsp_prod, bif.rsp_id} !== 18'h0) $display("FAIL arst_data got %h want 0", {bif.rsp_prod, bif.rsp_id});
        else n_pass++;
        #2;
        rst = 1'b0;
        tick();
        set_op(0, 8'sd9, -8'sd11);
        set_op(2, 8'sd2, 8'sd2);
        bif.req_valid = 4'b0101;
        #1;
        n_checks++;
        if (bif.req_ready !== 4'b0001) $display("FAIL arst_priority got %b want 0001", bif.req_ready);
        else n_pass++;
        tick();
        bif.req_valid = 4'b0000;
        wait_rsp(ok);
        n_checks++;
        if (!ok) $display("FAIL arst_rsp timeout waiting rsp_valid");
        else if ({bif.rsp_prod, bif.rsp_id} !== {16'hFF9D, 2'd0})
            $display("FAIL arst_rsp got %h/%0d want ff9d/0", bif.rsp_prod, bif.rsp_id);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [17:0] exp_q [$];
        logic [17:0] e;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          prod;
        for (int c = 0; c < 2000; c++) begin
            bif.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                bif.req_a[i*8 +: 8] = 8'($urandom);
                bif.req_b[i*8 +: 8] = 8'($urandom);
            end
            bif.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (bif.req_valid[i] && bif.req_ready[i]) begin
                    ra = bif.req_a[i*8 +: 8];
                    rb = bif.req_b[i*8 +: 8];
                    prod = $signed(ra) * $signed(rb);
                    exp_q.push_back({2'(i), 16'(prod)});
                end
            end
            if (bif.rsp_valid === 1'b1 && bif.rsp_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_orphan got %h/%0d want no response", bif.rsp_prod, bif.rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.rsp_id, bif.rsp_prod} !== e)
                        $display("FAIL rand_rsp got %0d/%h want %0d/%h", bif.rsp_id, bif.rsp_prod, e[17:16], e[15:0]);
                    else n_pass++;
                end
            end
            tick();
        end
        bif.req_valid = 4'b0000;
        bif.rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bif.rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_orphan_drain got %h/%0d want no response", bif.rsp_prod, bif.rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.rsp_id, bif.rsp_prod} !== e)
                        $display("FAIL rand_drain got %0d/%h want %0d/%h", bif.rsp_id, bif.rsp_prod, e[17:16], e[15:0]);
                    else n_pass++;
                end
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rand_pending got %0d want 0 outstanding", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
